// File: rtl/split_block.sv
// split_block
// Serializes one NUM_BYTES-byte block into a byte stream, byte 0 first.
// A block enters on a valid/ready handshake. Bytes leave on a second
// valid/ready handshake that the downstream can stall.
//
// Ports:
//   clk_in          clock; all state changes on its rising edge
//   rst_in          asynchronous active-high reset
//   block_in        block to serialize; sampled only on a block handshake
//   valid_in        block_in is valid
//   ready_out       a block can be accepted this cycle
//   byte_out        current byte; holds its last value while not valid
//   byte_valid_out  byte_out is valid
//   byte_ready_in   downstream consumes byte_out this cycle
//   done_out        one-cycle pulse after the last byte of a block transfers
//
// Optional feature:
//   SPLIT_BLOCK_BUFFER_EN  adds a one-block holding buffer, so the next block
//                          can be accepted while the current one is streaming.
//
// NUM_BYTES must be at least 2.
module split_block #(
  parameter int NUM_BYTES = 16
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_BYTES-1:0][7:0] block_in,
  input  logic                      valid_in,
  output logic                      ready_out,
  output logic [7:0]                byte_out,
  output logic                      byte_valid_out,
  input  logic                      byte_ready_in,
  output logic                      done_out
);

  localparam int IW = $clog2(NUM_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_next_state;
  logic [NUM_BYTES-1:0][7:0]   r_shift;
  logic [IW-1:0]               r_idx;
  logic                        w_accept;
  logic                        w_xfer;
  logic                        w_last;
  logic                        w_load;
  logic [NUM_BYTES-1:0][7:0]   w_load_data;

`ifdef SPLIT_BLOCK_BUFFER_EN
  logic [NUM_BYTES-1:0][7:0]   r_buf;
  logic                        r_buf_full;
  logic                        w_buf_wr;
  logic                        w_from_buf;
`endif

  // Output decode. Every output is a function of registered state only.
  assign byte_valid_out = (r_state == S_SEND);
  assign done_out       = (r_state == S_DONE);
  // Byte 0 of the shift register is always the byte on offer. It is left
  // untouched on the final transfer, so byte_out holds its last value.
  assign byte_out       = r_shift[0];
`ifdef SPLIT_BLOCK_BUFFER_EN
  assign ready_out      = !r_buf_full;
  assign w_load_data    = w_from_buf ? r_buf : block_in;
`else
  assign ready_out      = (r_state == S_IDLE);
  assign w_load_data    = block_in;
`endif

  assign w_accept = valid_in && ready_out;
  assign w_xfer   = (r_state == S_SEND) && byte_ready_in;
  assign w_last   = (r_idx == IW'(NUM_BYTES - 1));

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and load/buffer control.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
`ifdef SPLIT_BLOCK_BUFFER_EN
    w_buf_wr     = 1'b0;
    w_from_buf   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
`ifdef SPLIT_BLOCK_BUFFER_EN
        // The buffer can still be full here if a block landed in it during
        // DONE. ready_out is low in that case, so it cannot clash with a new
        // accept.
        if (r_buf_full) begin
          w_load       = 1'b1;
          w_from_buf   = 1'b1;
          w_next_state = S_SEND;
        end else if (w_accept) begin
          w_load       = 1'b1;
          w_next_state = S_SEND;
        end else begin
          w_next_state = S_IDLE;
        end
`else
        if (w_accept) begin
          w_load       = 1'b1;
          w_next_state = S_SEND;
        end else begin
          w_next_state = S_IDLE;
        end
`endif
      end
      S_SEND: begin
        if (w_xfer && w_last) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_SEND;
        end
`ifdef SPLIT_BLOCK_BUFFER_EN
        if (w_accept) begin
          w_buf_wr = 1'b1;
        end else begin
          w_buf_wr = 1'b0;
        end
`endif
      end
      S_DONE: begin
`ifdef SPLIT_BLOCK_BUFFER_EN
        if (r_buf_full) begin
          w_load       = 1'b1;
          w_from_buf   = 1'b1;
          w_next_state = S_SEND;
        end else if (w_accept) begin
          w_buf_wr     = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_IDLE;
        end
`else
        w_next_state = S_IDLE;
`endif
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Shift register and byte index.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (w_load) begin
      r_shift <= w_load_data;
      r_idx   <= '0;
    end else if (w_xfer) begin
      if (w_last) begin
        r_idx <= '0;
      end else begin
        r_idx   <= r_idx + IW'(1);
        r_shift <= {8'h00, r_shift[NUM_BYTES-1:1]};
      end
    end else begin
      r_idx <= r_idx;
    end
  end

`ifdef SPLIT_BLOCK_BUFFER_EN
  // Holding buffer for a block accepted while the current one is busy.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else if (w_buf_wr) begin
      r_buf      <= block_in;
      r_buf_full <= 1'b1;
    end else if (w_from_buf) begin
      r_buf_full <= 1'b0;
    end else begin
      r_buf_full <= r_buf_full;
    end
  end
`endif

endmodule

// File: tb/tb_split_block.sv
module tb_split_block;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b1;
  logic [15:0][7:0] block_in = '0;
  logic             valid_in = 1'b0;
  logic             ready_out;
  logic [7:0]       byte_out;
  logic             byte_valid_out;
  logic             byte_ready_in = 1'b0;
  logic             done_out;

  int total = 0;
  int bad   = 0;

  split_block #(.NUM_BYTES(16)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .block_in       (block_in),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .byte_out       (byte_out),
    .byte_valid_out (byte_valid_out),
    .byte_ready_in  (byte_ready_in),
    .done_out       (done_out)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural model: the bytes still owed for the current block, a pending
  // done pulse and (optionally) one held block.
  logic [7:0]       mq[$];
  bit               m_done = 1'b0;
  bit               m_buf_full = 1'b0;
  logic [15:0][7:0] m_buf = '0;

  // Bytes seen leaving the DUT during a directed test.
  logic [7:0]       got[$];
  int               ndone;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_ready();
`ifdef SPLIT_BLOCK_BUFFER_EN
    return !m_buf_full;
`else
    return (mq.size() == 0) && !m_done;
`endif
  endfunction

  task automatic m_load(input logic [15:0][7:0] b);
    mq.delete();
    for (int i = 0; i < 16; i++) mq.push_back(b[i]);
  endtask

  task automatic model_step();
    bit was_send;
    bit was_done;
    bit buf_before;
    bit acc;
    logic [7:0] dummy;
    if (rst_in) begin
      mq.delete();
      m_done = 1'b0;
      m_buf_full = 1'b0;
      return;
    end
    was_send   = (mq.size() != 0);
    was_done   = m_done;
    buf_before = m_buf_full;
    acc        = valid_in && m_ready();
    if (was_done) m_done = 1'b0;
    if (was_send && byte_ready_in) begin
      dummy = mq.pop_front();
      if (mq.size() == 0) m_done = 1'b1;
    end
    if (acc) begin
      if (!was_send && !was_done) begin
        m_load(block_in);
      end else begin
        m_buf = block_in;
        m_buf_full = 1'b1;
      end
    end
    if (buf_before && !was_send) begin
      m_load(m_buf);
      m_buf_full = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk_in or posedge rst_in);
    model_step();
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk_in);
    if (!rst_in) begin
      chk("valid", 32'(byte_valid_out), 32'(mq.size() != 0));
      chk("done", 32'(done_out), 32'(m_done));
      chk("ready", 32'(ready_out), 32'(m_ready()));
      if (mq.size() != 0) chk("byte", 32'(byte_out), 32'(mq[0]));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic do_reset();
    rst_in = 1'b1;
    valid_in = 1'b0;
    byte_ready_in = 1'b0;
    block_in = '0;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_valid", 32'(byte_valid_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    chk("rst_ready", 32'(ready_out), 32'd1);
    chk("rst_byte", 32'(byte_out), 32'h00);
    rst_in = 1'b0;
  endtask

  // Offers a block of base+i bytes; returns just after the accept edge.
  task automatic start_block(input logic [7:0] base, input bit keep_valid_ff);
    @(posedge clk_in);
    #1;
    for (int i = 0; i < 16; i++) block_in[i] = base + 8'(i);
    valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    if (keep_valid_ff) block_in = {16{8'hFF}};
    else valid_in = 1'b0;
  endtask

  // Collects transferred bytes until the first done pulse.
  task automatic collect(input int max_cyc, input bit toggle, input bit busy_chk);
    bit hold_prev = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    got.delete();
    ndone = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk_in);
      if (hold_prev) begin
        chk("hold_valid", 32'(byte_valid_out), 32'd1);
        chk("hold_byte", 32'(byte_out), 32'(prev_byte));
      end
      hold_prev = byte_valid_out && !byte_ready_in;
      prev_byte = byte_out;
      if (busy_chk && byte_valid_out) chk("busy_ready", 32'(ready_out), 32'd0);
      if (byte_valid_out && byte_ready_in) got.push_back(byte_out);
      if (done_out) begin
        ndone++;
        valid_in = 1'b0;
        break;
      end
      @(posedge clk_in);
      #1;
      if (toggle) byte_ready_in = ~byte_ready_in;
    end
    chk("collect_done", 32'(ndone), 32'd1);
  endtask

  task automatic check_got(input string name, input logic [7:0] base, input int n);
    chk({name, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      chk({name, "_data"}, 32'(got[i]), 32'(base + 8'(i % 16)));
  endtask

  initial begin
    int n;
    bit dseen;
    do_reset();

    // Basic serialization with fixed latencies.
    byte_ready_in = 1'b1;
    start_block(8'h00, 1'b0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_in);
      chk("basic_valid", 32'(byte_valid_out), 32'd1);
      chk("basic_byte", 32'(byte_out), 32'(k));
      chk("basic_nodone", 32'(done_out), 32'd0);
    end
    @(negedge clk_in);
    chk("basic_done", 32'(done_out), 32'd1);
    chk("basic_done_nv", 32'(byte_valid_out), 32'd0);
    chk("basic_done_nr", 32'(ready_out), 32'd0);
    @(negedge clk_in);
    chk("basic_ready", 32'(ready_out), 32'd1);
    chk("basic_done_off", 32'(done_out), 32'd0);

    // Backpressure: ready alternates 1,0,1,0...
    byte_ready_in = 1'b1;
    start_block(8'hA0, 1'b0);
    collect(100, 1'b1, 1'b0);
    check_got("bp", 8'hA0, 16);

`ifndef SPLIT_BLOCK_BUFFER_EN
    // A second block offered while busy is ignored.
    @(posedge clk_in);
    #1;
    byte_ready_in = 1'b1;
    start_block(8'h20, 1'b1);
    collect(60, 1'b0, 1'b1);
    check_got("busy", 8'h20, 16);
    repeat (5) @(negedge clk_in);
    chk("busy_idle", 32'(byte_valid_out), 32'd0);
`else
    // Back-to-back: B accepted during A's SEND and streamed right after done.
    do_reset();
    byte_ready_in = 1'b1;
    start_block(8'h50, 1'b0);
    for (int i = 0; i < 16; i++) block_in[i] = 8'h60 + 8'(i);
    valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
    got.delete();
    ndone = 0;
    dseen = 1'b0;
    // The accept edge of A is behind us; one byte already went out.
    got.push_back(8'h50);
    for (int c = 0; c < 80 && ndone < 2; c++) begin
      @(negedge clk_in);
      if (dseen) begin
        chk("b2b_first_valid", 32'(byte_valid_out), 32'd1);
        chk("b2b_first_byte", 32'(byte_out), 32'h60);
        dseen = 1'b0;
      end
      if (byte_valid_out && byte_ready_in) got.push_back(byte_out);
      if (done_out) begin
        ndone++;
        dseen = (ndone == 1);
      end
    end
    chk("b2b_ndone", 32'(ndone), 32'd2);
    chk("b2b_count", 32'(got.size()), 32'd32);
    for (int i = 0; i < 32 && i < got.size(); i++)
      chk("b2b_data", 32'(got[i]), 32'((i < 16) ? (8'h50 + 8'(i)) : (8'h60 + 8'(i - 16))));
`endif

    // Reset mid-block after 5 transfers.
    byte_ready_in = 1'b1;
    start_block(8'h40, 1'b0);
    n = 0;
    ndone = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk_in);
      if (byte_valid_out && byte_ready_in) n++;
      if (done_out) ndone++;
    end
    chk("mid_n", 32'(n), 32'd5);
    @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    #1;
    chk("mid_valid", 32'(byte_valid_out), 32'd0);
    chk("mid_done", 32'(done_out), 32'd0);
    chk("mid_ready", 32'(ready_out), 32'd1);
    chk("mid_byte", 32'(byte_out), 32'h00);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      if (done_out) ndone++;
    end
    chk("mid_nodone", 32'(ndone), 32'd0);
    start_block(8'h10, 1'b0);
    collect(60, 1'b0, 1'b0);
    check_got("after_rst", 8'h10, 16);

    // Idle quiet.
    do_reset();
    byte_ready_in = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_in);
      chk("quiet_valid", 32'(byte_valid_out), 32'd0);
      chk("quiet_done", 32'(done_out), 32'd0);
    end

    // Random traffic against the model.
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk_in);
      #1;
      valid_in = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < 16; i++) block_in[i] = 8'($urandom);
      byte_ready_in = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
    repeat (3) @(negedge clk_in);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
